// File: rtl/bus_slave_decoder_if.sv
// Master-side serial bus plus the fan-out to the slave ports, as seen by bus_slave_decoder.
// The decoder connects through the slave modport; the bench drives through the master modport.
interface bus_slave_decoder_if #(
  parameter int NUM_SLAVES = 4
);
  logic                  bus_busy;
  logic                  bus_mode;
  logic                  bus_wr;
  logic                  bus_master_valid;
  logic                  bus_master_ready;
  logic                  bus_slave_ready;
  logic                  bus_slave_valid;
  logic                  bus_rd;
  logic [NUM_SLAVES-1:0] s_mode;
  logic [NUM_SLAVES-1:0] s_wr_bus;
  logic [NUM_SLAVES-1:0] s_master_valid;
  logic [NUM_SLAVES-1:0] s_master_ready;
  logic [NUM_SLAVES-1:0] s_slave_ready;
  logic [NUM_SLAVES-1:0] s_slave_valid;
  logic [NUM_SLAVES-1:0] s_rd_bus;
  logic [NUM_SLAVES-1:0] slave_sel;
  logic                  dec_active;

  modport slave (
    input  bus_busy, bus_mode, bus_wr, bus_master_valid, bus_master_ready,
    input  s_slave_ready, s_slave_valid, s_rd_bus,
    output bus_slave_ready, bus_slave_valid, bus_rd,
    output s_mode, s_wr_bus, s_master_valid, s_master_ready,
    output slave_sel, dec_active
  );

  modport master (
    output bus_busy, bus_mode, bus_wr, bus_master_valid, bus_master_ready,
    output s_slave_ready, s_slave_valid, s_rd_bus,
    input  bus_slave_ready, bus_slave_valid, bus_rd,
    input  s_mode, s_wr_bus, s_master_valid, s_master_ready,
    input  slave_sel, dec_active
  );
endinterface

// File: rtl/bus_slave_decoder.sv
// Captures MSB-first device-select bits at the start of each grant, then routes the
// serial bus point-to-point between the master and the selected slave until bus_busy drops.
module bus_slave_decoder #(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_BITS   = 2
) (
  input  logic                clk,
  input  logic                rstn,
  bus_slave_decoder_if.slave  bif
);
  localparam int CNT_W = $clog2(SEL_BITS + 1);

  typedef enum logic [1:0] {IDLE, SEL, ROUTE} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [SEL_BITS-1:0]   r_sel_shift;
  logic [NUM_SLAVES-1:0] r_slave_sel;
  logic                  r_dec_active;

  logic                  w_route;
  logic                  w_sel_xfer;
  logic                  w_last_bit;
  logic [SEL_BITS-1:0]   w_sel_next;
  logic [NUM_SLAVES-1:0] w_onehot;

  assign w_route    = (r_state == ROUTE);
  // The decoder is always ready in SEL, so a select bit transfers whenever the master is valid.
  assign w_sel_xfer = (r_state == SEL) && bif.bus_master_valid;
  assign w_last_bit = (r_cnt == CNT_W'(SEL_BITS - 1));
  assign w_sel_next = SEL_BITS'({r_sel_shift, bif.bus_wr});
  assign w_onehot   = NUM_SLAVES'(1) << w_sel_next;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_sel_shift  <= '0;
      r_slave_sel  <= '0;
      r_dec_active <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt        <= '0;
          r_slave_sel  <= '0;
          r_dec_active <= 1'b0;
          if (bif.bus_busy) begin
            r_state <= SEL;
          end
        end
        SEL: begin
          if (!bif.bus_busy) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_sel_xfer) begin
            r_sel_shift <= w_sel_next;
            r_cnt       <= r_cnt + CNT_W'(1);
            if (w_last_bit) begin
              r_state      <= ROUTE;
              r_slave_sel  <= w_onehot;
              r_dec_active <= 1'b1;
            end
          end
        end
        ROUTE: begin
          if (!bif.bus_busy) begin
            r_state      <= IDLE;
            r_slave_sel  <= '0;
            r_dec_active <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_slave_sel  <= '0;
          r_dec_active <= 1'b0;
        end
      endcase
    end
  end

  // Forward path: each slave bit is gated by its own select bit, so unselected slaves stay quiet.
  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_fwd
    logic w_en;
    assign w_en                  = w_route && r_slave_sel[gi];
    assign bif.s_mode[gi]         = w_en && bif.bus_mode;
    assign bif.s_wr_bus[gi]       = w_en && bif.bus_wr;
    assign bif.s_master_valid[gi] = w_en && bif.bus_master_valid;
    assign bif.s_master_ready[gi] = w_en && bif.bus_master_ready;
  end

  assign bif.bus_slave_ready = (r_state == SEL) || (w_route && |(bif.s_slave_ready & r_slave_sel));
  assign bif.bus_slave_valid = w_route && |(bif.s_slave_valid & r_slave_sel);
  assign bif.bus_rd          = w_route && |(bif.s_rd_bus & r_slave_sel);
  assign bif.slave_sel       = r_slave_sel;
  assign bif.dec_active      = r_dec_active;
endmodule

// File: tb/tb_bus_slave_decoder.sv
// Directed bench for bus_slave_decoder: a small behavioural model pushes expected outputs
// to a scoreboard as each cycle's stimulus is driven; they are popped and compared mid-cycle.
module tb_bus_slave_decoder;
  localparam int NS = 4;

  logic clk;
  logic rstn;

  bus_slave_decoder_if #(.NUM_SLAVES(NS)) bif ();

  bus_slave_decoder #(.NUM_SLAVES(NS), .SEL_BITS(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bif  (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit run_inv     = 1'b0;

  typedef struct {
    string       tag;
    logic [23:0] exp;
  } sb_t;
  sb_t sb_q[$];

  // Expected-behaviour state: 0 idle, 1 select, 2 route
  int         m_state = 0;
  int         m_cnt   = 0;
  logic [1:0] m_shift = 2'b00;
  int         m_idx   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pack_dut();
    return {bif.bus_slave_ready, bif.bus_slave_valid, bif.bus_rd, bif.s_mode, bif.s_wr_bus,
            bif.s_master_valid, bif.s_master_ready, bif.slave_sel, bif.dec_active};
  endfunction

  function automatic logic [23:0] model_out();
    logic       brdy, bval, brd, da;
    logic [3:0] sm, sw, smv, smr, ss;
    brdy = 1'b0; bval = 1'b0; brd = 1'b0; da = 1'b0;
    sm = 4'b0; sw = 4'b0; smv = 4'b0; smr = 4'b0; ss = 4'b0;
    if (m_state == 1) begin
      brdy = 1'b1;
    end else if (m_state == 2) begin
      ss   = 4'b0001 << m_idx;
      da   = 1'b1;
      sm   = bif.bus_mode         ? ss : 4'b0;
      sw   = bif.bus_wr           ? ss : 4'b0;
      smv  = bif.bus_master_valid ? ss : 4'b0;
      smr  = bif.bus_master_ready ? ss : 4'b0;
      brdy = bif.s_slave_ready[m_idx];
      bval = bif.s_slave_valid[m_idx];
      brd  = bif.s_rd_bus[m_idx];
    end
    return {brdy, bval, brd, sm, sw, smv, smr, ss, da};
  endfunction

  task automatic model_step();
    if (!rstn) begin
      m_state = 0; m_cnt = 0; m_shift = 2'b00;
    end else if (m_state == 0) begin
      m_cnt = 0;
      if (bif.bus_busy) m_state = 1;
    end else if (m_state == 1) begin
      if (!bif.bus_busy) begin
        m_state = 0; m_cnt = 0;
      end else if (bif.bus_master_valid) begin
        m_shift = {m_shift[0], bif.bus_wr};
        m_cnt++;
        if (m_cnt == 2) begin
          m_state = 2; m_idx = int'(m_shift);
        end
      end
    end else begin
      if (!bif.bus_busy) m_state = 0;
    end
  endtask

  // One clock: expected pushed at drive time, popped and compared at the falling edge.
  task automatic cycle(input string tag);
    sb_t e;
    e.tag = tag;
    e.exp = model_out();
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check(e.tag, {8'b0, pack_dut()}, {8'b0, e.exp});
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn();
    bif.bus_busy = 1'b1;
    bif.bus_master_valid = 1'b0;
    cycle("busy_rise");
  endtask

  task automatic sel_bit(input logic b);
    bif.bus_master_valid = 1'b1;
    bif.bus_wr = b;
    cycle("sel_bit");
    bif.bus_master_valid = 1'b0;
  endtask

  task automatic end_txn();
    bif.bus_busy = 1'b0;
    bif.bus_master_valid = 1'b0;
    bif.bus_master_ready = 1'b0;
    cycle("busy_drop");
    check("sel_cleared", {28'b0, bif.slave_sel}, 32'h0);
    check("dec_cleared", {31'b0, bif.dec_active}, 32'h0);
  endtask

  // Unselected slaves must never see master_valid / master_ready.
  always @(negedge clk) begin
    if (run_inv) begin
      vectors++;
      assert (((bif.s_master_valid | bif.s_master_ready) & ~bif.slave_sel) === 4'b0) else begin
        miscompares++;
        $error("FAIL onehot_gate observed=%b expected=0000",
               (bif.s_master_valid | bif.s_master_ready) & ~bif.slave_sel);
      end
    end
  end

  logic [7:0] rd_pat;
  logic [7:0] rd_got;

  initial begin
    rstn = 1'b0;
    bif.bus_busy = 1'b0; bif.bus_mode = 1'b0; bif.bus_wr = 1'b0;
    bif.bus_master_valid = 1'b0; bif.bus_master_ready = 1'b0;
    bif.s_slave_ready = 4'b0; bif.s_slave_valid = 4'b0; bif.s_rd_bus = 4'b0;
    @(posedge clk);
    #1;
    run_inv = 1'b1;
    cycle("reset");
    check("reset_sel", {28'b0, bif.slave_sel}, 32'h0);
    check("reset_active", {31'b0, bif.dec_active}, 32'h0);
    rstn = 1'b1;
    cycle("idle");

    // Write: select 0,1 -> one-hot 0010, then 12 address + 8 data bits
    start_txn();
    check("sel_not_routing", {31'b0, bif.dec_active}, 32'h0);
    sel_bit(1'b0);
    sel_bit(1'b1);
    check("wr_sel", {28'b0, bif.slave_sel}, 32'h2);
    check("wr_active", {31'b0, bif.dec_active}, 32'h1);
    bif.bus_mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bif.bus_wr = 1'($urandom_range(0, 1));
      bif.bus_master_valid = 1'($urandom_range(0, 1));
      bif.s_slave_ready = 4'($urandom);
      cycle("wr_data");
    end
    end_txn();

    // Read from the bridge: select 1,1 -> 1000, read pattern A5 with zero latency
    start_txn();
    sel_bit(1'b1);
    sel_bit(1'b1);
    check("rd_sel", {28'b0, bif.slave_sel}, 32'h8);
    bif.bus_mode = 1'b0;
    bif.bus_master_ready = 1'b1;
    rd_pat = 8'hA5;
    rd_got = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      bif.s_slave_valid = {1'b1, 3'($urandom)};
      bif.s_rd_bus = {rd_pat[i], 3'($urandom)};
      cycle("rd_data");
      rd_got = {rd_got[6:0], bif.bus_rd};
    end
    check("rd_byte", {24'b0, rd_got}, 32'hA5);
    bif.s_slave_valid = 4'b0;
    bif.s_rd_bus = 4'b0;
    end_txn();

    // Abort in SEL after one bit, then select 0,0 -> slave 0
    start_txn();
    sel_bit(1'b1);
    end_txn();
    check("abort_ready", {31'b0, bif.bus_slave_ready}, 32'h0);
    start_txn();
    sel_bit(1'b0);
    sel_bit(1'b0);
    check("abort_next_sel", {28'b0, bif.slave_sel}, 32'h1);
    bif.bus_master_valid = 1'b1;
    cycle("s0_data");

    // Back-to-back: one low cycle, then select 1,0 -> 0100
    end_txn();
    start_txn();
    sel_bit(1'b1);
    sel_bit(1'b0);
    check("b2b_sel", {28'b0, bif.slave_sel}, 32'h4);
    bif.bus_master_valid = 1'b1;
    bif.bus_wr = 1'b1;
    cycle("s2_data");
    end_txn();

    // Stalled select: 3 idle cycles between the two bits
    start_txn();
    sel_bit(1'b1);
    for (int i = 0; i < 3; i++) begin
      bif.bus_wr = 1'b0;
      cycle("stall");
    end
    check("stall_not_active", {31'b0, bif.dec_active}, 32'h0);
    sel_bit(1'b1);
    check("stall_sel", {28'b0, bif.slave_sel}, 32'h8);

    // Reset in ROUTE mid-data
    bif.bus_master_valid = 1'b1;
    bif.bus_master_ready = 1'b1;
    bif.bus_mode = 1'b1;
    bif.s_slave_ready = 4'hF;
    cycle("route_data");
    rstn = 1'b0;
    cycle("rst_route");
    check("rst_sel", {28'b0, bif.slave_sel}, 32'h0);
    check("rst_active", {31'b0, bif.dec_active}, 32'h0);
    check("rst_outputs", {8'b0, pack_dut()}, 32'h0);
    rstn = 1'b1;
    bif.bus_busy = 1'b0;
    bif.bus_master_valid = 1'b0;
    bif.bus_master_ready = 1'b0;
    cycle("post_rst_idle");
    cycle("post_rst_idle");

    run_inv = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
